// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_arbiter
// Brief    : Two-requester valid/ready arbiter that issues one command at a
//            time to a shared combinational ALU and returns {Y1,Y2} tagged
//            with the requester id. Optional macro ALU_ARB_FIXED_PRIO_EN
//            selects fixed priority (req0 wins) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned FMA_LAT   = 4,
    parameter int unsigned DBL_EXTRA = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [6:0]   req0_cmd_i,
    input  logic [127:0] req0_opnd_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [6:0]   req1_cmd_i,
    input  logic [127:0] req1_opnd_i,
    output logic [2:0]   alu_op_o,
    output logic         alu_floating_o,
    output logic         alu_form_o,
    output logic [1:0]   alu_precision_o,
    output logic [31:0]  alu_a_o,
    output logic [31:0]  alu_b_o,
    output logic [31:0]  alu_c_o,
    output logic [31:0]  alu_d_o,
    input  logic [31:0]  alu_y1_i,
    input  logic [31:0]  alu_y2_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [63:0]  rsp_y_o,
    output logic         busy_o
);

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_FMA = 3'b110;
    localparam logic [1:0] PREC_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           rr_ptr_q, rr_ptr_d;
    logic [6:0]     cmd_q, cmd_d;
    logic [127:0]   opnd_q, opnd_d;
    logic           id_q, id_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [63:0]    rsp_y_q, rsp_y_d;

    logic           grant;
    logic           grant_valid;
    logic           handshake;
    logic [6:0]     sel_cmd;
    logic [127:0]   sel_opnd;
    logic [3:0]     dbl_ext;
    logic [3:0]     lat;

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = ~req0_valid_i;
`else
        grant = (req0_valid_i && req1_valid_i) ? rr_ptr_q : req1_valid_i;
`endif
    end

    assign grant_valid  = grant ? req1_valid_i : req0_valid_i;
    assign handshake    = (state_q == S_IDLE) && grant_valid;
    assign req0_ready_o = (state_q == S_IDLE) && req0_valid_i && !grant;
    assign req1_ready_o = (state_q == S_IDLE) && req1_valid_i && grant;
    assign sel_cmd      = grant ? req1_cmd_i  : req0_cmd_i;
    assign sel_opnd     = grant ? req1_opnd_i : req0_opnd_i;

    always_comb begin
        dbl_ext = (sel_cmd[1:0] == PREC_DOUBLE) ? 4'(DBL_EXTRA) : 4'd0;
        case (sel_cmd[6:4])
            OP_MUL:  lat = 4'(MUL_LAT) + dbl_ext;
            OP_FMA:  lat = 4'(FMA_LAT) + dbl_ext;
            default: lat = 4'd1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_d       = cmd_q;
        opnd_d      = opnd_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    cmd_d    = sel_cmd;
                    opnd_d   = sel_opnd;
                    id_d     = grant;
                    rr_ptr_d = ~grant;
                    cnt_d    = lat - 4'd1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                // ALU results are only trusted in the last EXEC cycle
                if (cnt_q == 4'd0) begin
                    rsp_y_d     = {alu_y1_i, alu_y2_i};
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            cmd_q       <= '0;
            opnd_q      <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_q       <= cmd_d;
            opnd_q      <= opnd_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
        end
    end

    // The latched command feeds the ALU directly, so it holds through DONE/IDLE
    assign alu_op_o        = cmd_q[6:4];
    assign alu_floating_o  = cmd_q[3];
    assign alu_form_o      = cmd_q[2];
    assign alu_precision_o = cmd_q[1:0];
    assign alu_a_o         = opnd_q[127:96];
    assign alu_b_o         = opnd_q[95:64];
    assign alu_c_o         = opnd_q[63:32];
    assign alu_d_o         = opnd_q[31:0];

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_y_o     = rsp_y_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_arbiter
// Brief    : Directed self-checking bench for alu_issue_arbiter with a
//            behavioural ALU; honours ALU_ARB_FIXED_PRIO_EN for grant checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v0, v1, r0, r1;
    logic [6:0]   c0, c1;
    logic [127:0] o0, o1;
    logic [2:0]   alu_op;
    logic         alu_floating, alu_form;
    logic [1:0]   alu_precision;
    logic [31:0]  alu_a, alu_b, alu_c, alu_d;
    logic [31:0]  y1, y2;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [63:0]  rsp_y;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] ADD_FULL = {3'b000, 1'b0, 1'b0, 2'b10};
    localparam logic [6:0] MUL_FULL = {3'b010, 1'b0, 1'b0, 2'b10};
    localparam logic [6:0] MUL_DBL  = {3'b010, 1'b0, 1'b0, 2'b11};
    localparam logic [6:0] FMA_FULL = {3'b110, 1'b0, 1'b0, 2'b10};

    always #5 clk = ~clk;

    alu_issue_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req0_valid_i    (v0),
        .req0_ready_o    (r0),
        .req0_cmd_i      (c0),
        .req0_opnd_i     (o0),
        .req1_valid_i    (v1),
        .req1_ready_o    (r1),
        .req1_cmd_i      (c1),
        .req1_opnd_i     (o1),
        .alu_op_o        (alu_op),
        .alu_floating_o  (alu_floating),
        .alu_form_o      (alu_form),
        .alu_precision_o (alu_precision),
        .alu_a_o         (alu_a),
        .alu_b_o         (alu_b),
        .alu_c_o         (alu_c),
        .alu_d_o         (alu_d),
        .alu_y1_i        (y1),
        .alu_y2_i        (y2),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_id_o        (rsp_id),
        .rsp_y_o         (rsp_y),
        .busy_o          (busy)
    );

    always_comb begin
        case (alu_op)
            3'b000:  begin y1 = alu_a + alu_c;         y2 = alu_b + alu_d;         end
            3'b010:  begin y1 = alu_a * alu_c;         y2 = alu_b * alu_d;         end
            3'b110:  begin y1 = alu_a * alu_c + alu_b; y2 = alu_b * alu_d + alu_a; end
            default: begin y1 = alu_a ^ alu_c;         y2 = alu_b ^ alu_d;         end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {59'd0, rsp_valid, rsp_id, busy, r0, r1}, 64'd0);
        chk({tag, "_rsp_y"}, rsp_y, 64'd0);
        chk({tag, "_alu_ctl"}, {57'd0, alu_op, alu_floating, alu_form, alu_precision}, 64'd0);
        chk({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        chk({tag, "_alu_cd"}, {alu_c, alu_d}, 64'd0);
    endtask

    // Offers one command, expects acceptance, then lat EXEC cycles, then DONE.
    task automatic issue(input bit id, input logic [6:0] cmd, input logic [127:0] opnd,
                         input int lat, input logic [63:0] exp_y, input string tag);
        if (id) begin v1 = 1'b1; c1 = cmd; o1 = opnd; end
        else    begin v0 = 1'b1; c0 = cmd; o0 = opnd; end
        #1;
        chk({tag, "_ready"}, {62'd0, r1, r0}, id ? 64'd2 : 64'd1);
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_exec_flags"}, {62'd0, busy, rsp_valid}, 64'd2);
            chk({tag, "_exec_op"}, {61'd0, alu_op}, {61'd0, cmd[6:4]});
            tick();
        end
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({tag, "_rsp_id"}, {63'd0, rsp_id}, {63'd0, id});
        chk({tag, "_rsp_y"}, rsp_y, exp_y);
    endtask

    initial begin
        logic        eg;
        logic [63:0] held_y;

        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        c0 = '0; c1 = '0; o0 = '0; o1 = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("idle_no_valid_ready", {62'd0, r0, r1}, 64'd0);

        // ADD: 5+7=12, 1+2=3
        issue(1'b0, ADD_FULL, {32'd5, 32'd1, 32'd7, 32'd2}, 1, {32'd12, 32'd3}, "t1_add");
        rsp_ready = 1'b1;
        tick();
        chk("t1_release", {62'd0, rsp_valid, busy}, 64'd0);

        // MUL 3*4=12, 5*6=30; DOUBLE 7*9=63, 2*3=6 with one extra cycle
        issue(1'b1, MUL_FULL, {32'd3, 32'd5, 32'd4, 32'd6}, 3, {32'd12, 32'd30}, "t3_mul");
        tick();
        issue(1'b1, MUL_DBL, {32'd7, 32'd2, 32'd9, 32'd3}, 4, {32'd63, 32'd6}, "t3_mul_dbl");
        tick();
        chk("t3_idle", {63'd0, busy}, 64'd0);

        // Both valid continuously with rr_ptr at 0
        v0 = 1'b1; c0 = ADD_FULL; o0 = {32'd1, 32'd2, 32'd3, 32'd4};
        v1 = 1'b1; c1 = ADD_FULL; o1 = {32'd100, 32'd200, 32'd1, 32'd2};
        for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            eg = 1'b0;
`else
            eg = g[0];
`endif
            #1;
            chk("t2_one_ready", {63'd0, r0 ^ r1}, 64'd1);
            chk("t2_grant", {63'd0, r1}, {63'd0, eg});
            tick();
            tick();
            chk("t2_rsp_id", {62'd0, rsp_valid, rsp_id}, {62'd0, 1'b1, eg});
            chk("t2_rsp_y", rsp_y, eg ? {32'd101, 32'd202} : {32'd4, 32'd6});
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b0;

        // Backpressure in DONE: 10+30=40, 20+40=60
        rsp_ready = 1'b0;
        issue(1'b0, ADD_FULL, {32'd10, 32'd20, 32'd30, 32'd40}, 1, {32'd40, 32'd60}, "t4_add");
        held_y = {32'd40, 32'd60};
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_flags", {60'd0, rsp_valid, rsp_id, r0, r1}, 64'h8);
            chk("t4_hold_y", rsp_y, held_y);
        end
        v0 = 1'b0; v1 = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("t4_released", {62'd0, rsp_valid, busy}, 64'd0);
        v0 = 1'b1; v1 = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        eg = 1'b0;
`else
        eg = 1'b1;
`endif
        #1;
        chk("t4_new_grant", {62'd0, r0, r1}, eg ? 64'd1 : 64'd2);
        v0 = 1'b0; v1 = 1'b0;

        // Reset in the middle of an FMA
        v0 = 1'b1; c0 = FMA_FULL; o0 = {32'd2, 32'd3, 32'd4, 32'd5};
        tick();
        v0 = 1'b0;
        tick();
        tick();
        chk("t5_busy_before_reset", {62'd0, busy, rsp_valid}, 64'd2);
        rst_n = 1'b0;
        tick();
        chk_all_zero("t5_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_rsp", {62'd0, rsp_valid, busy}, 64'd0);
        end

        // Requester drops valid while the block is busy
        rsp_ready = 1'b0;
        issue(1'b0, ADD_FULL, {32'd1, 32'd1, 32'd1, 32'd1}, 1, {32'd2, 32'd2}, "t6_add");
        v1 = 1'b1; c1 = MUL_FULL; o1 = {32'd9, 32'd9, 32'd9, 32'd9};
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t6_busy_no_ready", {62'd0, r0, r1}, 64'd0);
            tick();
        end
        v1 = 1'b0;
        rsp_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t6_no_latch", {62'd0, rsp_valid, busy}, 64'd0);
            tick();
        end
        v0 = 1'b1; v1 = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        eg = 1'b0;
`else
        eg = 1'b1;
`endif
        #1;
        chk("t6_rr_unchanged", {62'd0, r0, r1}, eg ? 64'd1 : 64'd2);
        v0 = 1'b0; v1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
